// File: rtl/orao_ce_pkg.sv
// Shared types and helpers for the clock-enable / reset generator.
// The reset sequencer state enum, default divisor width and the ce phase clip.
package orao_ce_pkg;

    typedef enum logic [1:0] {
        POR  = 2'd0,
        HOLD = 2'd1,
        RUN  = 2'd2
    } rst_state_e;

    localparam int DEFAULT_DIV_W = 8;

    // A phase beyond the current period would never match, so it folds back to 0.
    function automatic int unsigned ce_match_point(input int unsigned phase,
                                                   input int unsigned shadow);
        return (phase <= shadow) ? phase : 32'd0;
    endfunction

endpackage

// File: rtl/orao_ce_reset_gen_if.sv
// Bus between the emu top and the ce/reset generator.
// ORAO_CE_TURBO_EN adds the turbo request line.
interface orao_ce_reset_gen_if
    import orao_ce_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = DEFAULT_DIV_W
);

    logic [3:0]              rst_src;
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH-1:0]       hold;
    logic [NUM_CH-1:0]       ce;
    logic                    sys_reset;
    logic                    por_done;

`ifdef ORAO_CE_TURBO_EN
    logic                    turbo;

    modport master (output rst_src, div, hold, turbo, input ce, sys_reset, por_done);
    modport slave  (input rst_src, div, hold, turbo, output ce, sys_reset, por_done);
`else
    modport master (output rst_src, div, hold, input ce, sys_reset, por_done);
    modport slave  (input rst_src, div, hold, output ce, sys_reset, por_done);
`endif

endinterface

// File: rtl/orao_ce_div.sv
// One clock-enable channel: wrapping counter, shadowed divisor, phase match, output gate.
// ORAO_CE_TURBO_EN adds turbo_i, which halves the divisor loaded at wrap.
module orao_ce_div
    import orao_ce_pkg::*;
#(
    parameter int DIV_W    = DEFAULT_DIV_W,
    parameter int CE_PHASE = 8
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [DIV_W-1:0] div_i,
    input  logic             hold_i,
`ifdef ORAO_CE_TURBO_EN
    input  logic             turbo_i,
`endif
    output logic             ce_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] shadow_cur;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] match_pt;
    logic             first_q;
    logic             ce_q, ce_d;
    logic             wrap;

`ifdef ORAO_CE_TURBO_EN
    assign div_eff = turbo_i ? (div_i >> 1) : div_i;
`else
    assign div_eff = div_i;
`endif

    // Straight out of reset the shadow is the live divisor, so no constant-less async load is needed.
    assign shadow_cur = first_q ? div_eff : shadow_q;
    assign wrap       = (cnt_q == shadow_cur);
    assign match_pt   = DIV_W'(ce_match_point(unsigned'(CE_PHASE), 32'(shadow_cur)));

    always_comb begin
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        shadow_d = wrap ? div_eff : shadow_cur;
        ce_d     = (cnt_q == match_pt) && !hold_i;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            first_q  <= 1'b1;
            ce_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            first_q  <= 1'b0;
            ce_q     <= ce_d;
        end
    end

    assign ce_o = ce_q;

endmodule

// File: rtl/orao_ce_reset_gen.sv
// NUM_CH programmable clock-enable channels plus a POR / hold / run reset sequencer.
// ORAO_CE_TURBO_EN routes the turbo request to channel 0 only.
module orao_ce_reset_gen
    import orao_ce_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DIV_W      = DEFAULT_DIV_W,
    parameter int CE_PHASE   = 8,
    parameter int POR_CYCLES = 20000000,
    parameter int RST_HOLD   = 15
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    orao_ce_reset_gen_if.slave  bus
);

    localparam int POR_W  = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [POR_W-1:0]  POR_LOAD  = POR_W'(POR_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    logic [NUM_CH-1:0] ce_w;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            orao_ce_div #(
                .DIV_W    (DIV_W),
                .CE_PHASE (CE_PHASE)
            ) u_div (
                .clk_sys (clk_sys),
                .reset_n (reset_n),
                .div_i   (bus.div[gi*DIV_W +: DIV_W]),
                .hold_i  (bus.hold[gi]),
`ifdef ORAO_CE_TURBO_EN
                .turbo_i ((gi == 0) ? bus.turbo : 1'b0),
`endif
                .ce_o    (ce_w[gi])
            );
        end
    endgenerate

    assign bus.ce = ce_w;

    rst_state_e        state_q, state_d;
    logic [POR_W-1:0]  por_cnt_q, por_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              sys_reset_q, sys_reset_d;
    logic              por_done_q, por_done_d;
    logic              rst_req;

    assign rst_req = |bus.rst_src;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= POR;
            por_cnt_q   <= POR_LOAD;
            hold_cnt_q  <= '0;
            sys_reset_q <= 1'b1;
            por_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            por_cnt_q   <= por_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            sys_reset_q <= sys_reset_d;
            por_done_q  <= por_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        por_cnt_d  = por_cnt_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            POR: begin
                if (por_cnt_q == '0) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end else begin
                    por_cnt_d = por_cnt_q - 1'b1;
                end
            end
            HOLD: begin
                // A request on the completing cycle wins: the count restarts instead of releasing.
                if (rst_req) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (rst_req) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d = POR;
            end
        endcase
    end

    // Registered from the next state so sys_reset tracks the state with no extra cycle of lag.
    always_comb begin
        sys_reset_d = (state_d != RUN);
        por_done_d  = por_done_q | (state_d != POR);
    end

    assign bus.sys_reset = sys_reset_q;
    assign bus.por_done  = por_done_q;

endmodule
